// File: rtl/bcd_pkg.sv
// Shared types and status-word layout for the packed-BCD to binary converter.
package bcd_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      CONV = 1'b1
   } state_t;

   localparam int DONE_BIT = 31;
   localparam int ERR_BIT  = 30;
   localparam int BUSY_BIT = 29;

   // 24 bits hold 9,999,999, the largest 7-digit value.
   localparam int ACC_W = 24;

   localparam logic [31:0] ST_BUSY = 32'h1 << BUSY_BIT;
   localparam logic [31:0] ST_DONE = 32'h1 << DONE_BIT;
   localparam logic [31:0] ST_ERR  = (32'h1 << DONE_BIT) | (32'h1 << ERR_BIT);

endpackage

// File: rtl/bcd_digit_mac.sv
// One decimal step: acc*10 + digit built from shifts and adds, plus a digit-valid flag.
// Purely combinational.
module bcd_digit_mac
   import bcd_pkg::*;
(
   input  logic [ACC_W-1:0] i_acc,
   input  logic [3:0]       i_digit,
   output logic [ACC_W-1:0] o_acc,
   output logic             o_digit_ok
);

   assign o_acc      = (i_acc << 3) + (i_acc << 1) + {{(ACC_W-4){1'b0}}, i_digit};
   assign o_digit_ok = (i_digit <= 4'd9);

endmodule

// File: rtl/peri_bin_from_bcd.sv
// Bus peripheral converting NUM_DIGITS packed BCD digits to binary, one digit per clock, MSD first.
// Result/status word is updated NUM_DIGITS edges after the write edge; a new write restarts at once.
module peri_bin_from_bcd
   import bcd_pkg::*;
#(
   parameter int NUM_DIGITS = 6
)
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        we_i,
   input  logic [31:0] data_i,
   output logic [31:0] salida_o
);

   localparam int         SW   = 4 * NUM_DIGITS;
   localparam logic [2:0] LAST = 3'(NUM_DIGITS - 1);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [SW-1:0]    r_shift;
   logic [SW-1:0]    w_shift_nxt;
   logic [ACC_W-1:0] r_acc;
   logic [ACC_W-1:0] w_acc_nxt;
   logic [ACC_W-1:0] w_mac_acc;
   logic [2:0]       r_cnt;
   logic [2:0]       w_cnt_nxt;
   logic [31:0]      r_salida;
   logic [31:0]      w_salida_nxt;
   logic             w_digit_ok;
   logic             w_unused_data;

   // Digits above the configured count are don't-care.
   assign w_unused_data = ^data_i;

   bcd_digit_mac u_mac (
      .i_acc      (r_acc),
      .i_digit    (r_shift[SW-1 -: 4]),
      .o_acc      (w_mac_acc),
      .o_digit_ok (w_digit_ok)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_shift_nxt  = r_shift;
      w_acc_nxt    = r_acc;
      w_cnt_nxt    = r_cnt;
      w_salida_nxt = r_salida;

      if (we_i) begin
         // A write always wins, silently dropping any conversion in flight.
         w_state_nxt  = CONV;
         w_shift_nxt  = data_i[SW-1:0];
         w_acc_nxt    = '0;
         w_cnt_nxt    = '0;
         w_salida_nxt = ST_BUSY;
      end else if (r_state == CONV) begin
         if (!w_digit_ok) begin
            w_state_nxt  = IDLE;
            w_salida_nxt = ST_ERR;
         end else begin
            w_acc_nxt   = w_mac_acc;
            w_shift_nxt = r_shift << 4;
            w_cnt_nxt   = r_cnt + 3'd1;
            if (r_cnt == LAST) begin
               w_state_nxt  = IDLE;
               w_salida_nxt = ST_DONE | {8'h00, w_mac_acc};
            end
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_shift  <= '0;
         r_acc    <= '0;
         r_cnt    <= '0;
         r_salida <= '0;
      end else begin
         r_shift  <= w_shift_nxt;
         r_acc    <= w_acc_nxt;
         r_cnt    <= w_cnt_nxt;
         r_salida <= w_salida_nxt;
      end
   end

   assign salida_o = r_salida;

endmodule

// File: tb/tb_peri_bin_from_bcd.sv
// Directed bench for peri_bin_from_bcd (NUM_DIGITS=6) with a result scoreboard.
module tb_peri_bin_from_bcd;

   logic        clk_i;
   logic        rst_i;
   logic        we_i;
   logic [31:0] data_i;
   logic [31:0] salida_o;

   int          n_assert;
   int          n_fail;
   int          n_pushed;
   int          n_done_seen;
   logic [31:0] exp_q[$];

   peri_bin_from_bcd #(.NUM_DIGITS(6)) dut (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .we_i     (we_i),
      .data_i   (data_i),
      .salida_o (salida_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic do_write(input logic [31:0] d, input bit push, input logic [31:0] e);
      @(negedge clk_i);
      we_i   = 1'b1;
      data_i = d;
      if (push) begin
         exp_q.push_back(e);
         n_pushed++;
      end
      @(negedge clk_i);
      we_i   = 1'b0;
      data_i = $urandom;
      chk("load_busy", salida_o, 32'h2000_0000);
   endtask

   task automatic busy_edges(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk_i);
         #1;
         chk("busy", salida_o, 32'h2000_0000);
      end
   endtask

   task automatic run_edges(input int n, input logic [31:0] last_word, input string tag);
      for (int i = 1; i <= n; i++) begin
         @(posedge clk_i);
         #1;
         chk("busy_done_excl", {31'b0, salida_o[31] & salida_o[29]}, 32'h0);
         if (i < n) chk("busy", salida_o, 32'h2000_0000);
         else       chk(tag, salida_o, last_word);
      end
   endtask

   task automatic hold(input int n, input logic [31:0] w, input string tag);
      for (int i = 0; i < n; i++) begin
         @(posedge clk_i);
         #1;
         chk(tag, salida_o, w);
      end
   endtask

   // Scoreboard: every busy->done transition is one produced result.
   initial begin
      logic [31:0] prev;
      logic [31:0] e;
      prev = '0;
      forever begin
         @(posedge clk_i);
         #1;
         if (!rst_i && prev[29] && salida_o[31]) begin
            n_done_seen++;
            n_assert++;
            assert (exp_q.size() != 0) else begin
               n_fail++;
               $error("FAIL unexpected_result: observed=%h expected=none", salida_o);
            end
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               chk("scoreboard", salida_o, e);
            end
         end
         prev = salida_o;
      end
   end

   initial begin
      n_assert    = 0;
      n_fail      = 0;
      n_pushed    = 0;
      n_done_seen = 0;
      rst_i       = 1'b1;
      we_i        = 1'b0;
      data_i      = '0;
      #3;
      chk("reset_state", salida_o, 32'h0);
      repeat (2) @(negedge clk_i);
      rst_i = 1'b0;
      hold(3, 32'h0, "idle_after_reset");

      do_write(32'h0012_3456, 1'b1, 32'h8001_E240);
      run_edges(6, 32'h8001_E240, "conv_123456");
      hold(8, 32'h8001_E240, "idle_hold");

      do_write(32'h0099_9999, 1'b1, 32'h800F_423F);
      run_edges(6, 32'h800F_423F, "conv_999999");

      do_write(32'h0000_0000, 1'b1, 32'h8000_0000);
      run_edges(6, 32'h8000_0000, "conv_zero");

      do_write(32'h0012_A456, 1'b1, 32'hC000_0000);
      run_edges(3, 32'hC000_0000, "bad_digit");
      hold(6, 32'hC000_0000, "error_hold");

      do_write(32'h0011_1111, 1'b0, 32'h0);
      busy_edges(2);
      do_write(32'h0000_0042, 1'b1, 32'h8000_002A);
      run_edges(6, 32'h8000_002A, "restart");

      do_write(32'hFF00_0007, 1'b1, 32'h8000_0007);
      run_edges(6, 32'h8000_0007, "upper_ignored");

      do_write(32'h0012_3456, 1'b0, 32'h0);
      busy_edges(2);
      #2;
      rst_i = 1'b1;
      #1;
      chk("rst_async", salida_o, 32'h0);
      @(negedge clk_i);
      #2;
      rst_i = 1'b0;
      hold(8, 32'h0, "rst_idle");

      @(negedge clk_i);
      chk("results_count", 32'(n_done_seen), 32'(n_pushed));
      chk("queue_empty", 32'(exp_q.size()), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/peri_bin_from_bcd.md
PERI_BIN_FROM_BCD -- requirements
Module: peri_bin_from_bcd

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 6, giving the number of packed BCD digits converted (legal range 1..7).
REQ-002 SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_i, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port we_i, input, 1 bit: bus write strobe; when high, data_i is loaded and a conversion starts.
REQ-005 SHALL have port data_i, input, 32 bits: packed BCD digits, digit k in bits [4k+3:4k], MSD at k=NUM_DIGITS-1; bits above 4*NUM_DIGITS-1 are ignored.
REQ-006 SHALL have port salida_o, output, 32 bits, registered status/result word:
- bit31 = done
- bit30 = error
- bit29 = busy
- bits[28:24] = 0
- bits[23:0] = binary result.

Function
REQ-007 SHALL implement a two-state FSM with states IDLE and CONV.
REQ-008 SHALL, on an edge with we_i=1 (any state), perform all of the following:
- capture data_i into the digit shift register
- clear the accumulator and the digit counter
- enter CONV
- set salida_o to 0x20000000.
REQ-009 SHALL, in CONV, consume one digit per edge, MSD first, computing acc <= acc*10 + digit, with acc*10 formed as (acc<<3)+(acc<<1) (no multiplier).
REQ-010 SHALL size the accumulator at 24 bits; no overflow occurs for NUM_DIGITS<=7 (max 9,999,999 < 2^24).
REQ-011 SHALL, on the edge consuming the last digit, perform all of the following:
- write salida_o = {1'b1, 1'b0, 1'b0, 5'b0, final acc}
- return to IDLE.
Latency: result valid exactly NUM_DIGITS edges after the load edge.
REQ-012 SHALL, when the digit being consumed is >9, perform all of the following on that edge:
- abort the conversion
- set salida_o = 0xC0000000 (done=1, error=1, result 0)
- return to IDLE
- ignore the remaining digits.
REQ-013 SHALL give we_i=1 in CONV priority over digit processing: the conversion restarts with the new data and the old one is discarded, with no result or error reported for it.
REQ-014 SHALL, in IDLE with we_i=0, hold salida_o unchanged indefinitely.
REQ-015 SHALL never assert busy and done simultaneously.

Reset
REQ-016 SHALL, while rst_i=1, immediately (asynchronously) force all of the following:
- state IDLE
- accumulator, counter and shift register to 0
- salida_o to 0x00000000.
REQ-017 SHALL, on reset asserted mid-conversion, discard the conversion; after release the block idles until the next we_i.

Structure
REQ-018 SHALL place the FSM state typedef (IDLE, CONV) and the status bit-position constants (DONE_BIT=31, ERR_BIT=30, BUSY_BIT=29) in shared package bcd_pkg.
REQ-019 SHALL isolate the digit step (acc*10+digit, digit-valid flag) in one combinational sub-module, bcd_digit_mac; the FSM, counter and registers stay in peri_bin_from_bcd.

Verification (NUM_DIGITS=6)
REQ-020 SHALL cover: write 0x00123456 -> salida_o = 0x20000000 for 5 edges, then 0x8001E240 on the 6th edge after load.
REQ-021 SHALL cover: write 0x00999999 -> 0x800F423F after 6 edges; write 0x00000000 -> 0x80000000 after 6 edges.
REQ-022 SHALL cover: write 0x0012A456 -> 0xC0000000 on the 3rd edge after load (digit 'A' consumed), and busy never reasserts until the next write.
REQ-023 SHALL cover: write 0x00111111, then write 0x00000042 on the 3rd edge -> no intermediate done; 0x8000002A 6 edges after the second write.
REQ-024 SHALL cover: write 0xFF000007 (upper bits ignored) -> 0x80000007; rst_i pulsed mid-conversion, asynchronously between edges -> salida_o = 0x00000000 immediately and held until the next write.
